// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO read-side controller.
// Holds the FSM encoding, the skid depth and the room test used to gate rd_enable.
package fifo_reader_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_WIDTH  = $clog2(SKID_DEPTH + 1);

  // True when buffered words plus the in-flight read, less this cycle's pop, leave a free slot.
  function automatic logic has_room(input logic [OCC_WIDTH-1:0] occ,
                                    input logic                 pend,
                                    input logic                 pop);
    logic [OCC_WIDTH:0] projected;
    projected = {1'b0, occ} + {{OCC_WIDTH{1'b0}}, pend} - {{OCC_WIDTH{1'b0}}, pop};
    return projected < (OCC_WIDTH + 1)'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Small in-order skid buffer: slot 0 is the head, pops shift toward it,
// pushes land just behind the last word that survives this cycle's pop.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int data_width = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [data_width-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_WIDTH-1:0]  occ,
  output logic [data_width-1:0] head,
  output logic                  valid
);

  logic [OCC_WIDTH-1:0]  occ_reg;
  logic [OCC_WIDTH-1:0]  occ_next;
  logic [OCC_WIDTH-1:0]  wr_idx;
  logic [data_width-1:0] slot_q [SKID_DEPTH];

  // A simultaneous pop frees the head first, so the new word lands one slot earlier.
  assign wr_idx   = occ_reg - OCC_WIDTH'(pop);
  assign occ_next = occ_reg + OCC_WIDTH'(push) - OCC_WIDTH'(pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_reg <= '0;
    end else begin
      occ_reg <= occ_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_slot
      logic [data_width-1:0] data_reg;
      logic [data_width-1:0] data_next;
      logic [data_width-1:0] shift_src;

      if (gi < SKID_DEPTH - 1) begin : g_mid
        assign shift_src = slot_q[gi+1];
      end else begin : g_tail
        assign shift_src = data_reg;
      end

      always_comb begin
        data_next = data_reg;
        if (pop) begin
          data_next = shift_src;
        end
        if (push && (wr_idx == OCC_WIDTH'(gi))) begin
          data_next = push_data;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_reg <= '0;
        end else begin
          data_reg <= data_next;
        end
      end

      assign slot_q[gi] = data_reg;
    end
  endgenerate

  assign occ   = occ_reg;
  assign head  = slot_q[0];
  assign valid = (occ_reg != '0);

endmodule

// File: rtl/fifo_reader.sv
// Read-side FIFO controller: pops the FIFO, absorbs its 1-cycle read latency in a skid
// buffer and presents words on valid/ready. Optional burst start: FIFO_READER_LOWWATER_EN.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int data_width  = 10,
  parameter int count_width = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   empty_fifo,
  input  logic                   almost_empty_fifo,
  input  logic                   error,
  input  logic [data_width-1:0]  fifo_data,
  output logic                   rd_enable,
  output logic [data_width-1:0]  data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   err_o,
  output logic [count_width-1:0] words_read
);

  state_t                 state_reg;
  state_t                 state_next;
  logic                   pend_reg;
  logic                   err_reg;
  logic [count_width-1:0] count_reg;
  logic [OCC_WIDTH-1:0]   occ;
  logic                   pop;
  logic                   start;

  assign pop = valid_o & ready_i;

`ifdef FIFO_READER_LOWWATER_EN
  assign start = !almost_empty_fifo;
`else
  logic unused_almost_empty;
  assign unused_almost_empty = almost_empty_fifo;
  assign start = !empty_fifo;
`endif

  always_comb begin
    state_next = state_reg;
    rd_enable  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rd_enable = !empty_fifo && has_room(occ, pend_reg, pop);
        if (empty_fifo && !rd_enable) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // pend_reg marks the cycle in which fifo_data carries the word requested one cycle earlier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      pend_reg  <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= rd_enable;
      err_reg   <= err_reg | error;
      if (pop) begin
        count_reg <= count_reg + count_width'(1);
      end
    end
  end

  fifo_reader_skid #(
    .data_width(data_width)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (pend_reg),
    .push_data (fifo_data),
    .pop       (pop),
    .occ       (occ),
    .head      (data_o),
    .valid     (valid_o)
  );

  assign err_o      = err_reg;
  assign words_read = count_reg;

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: behavioural FIFO with 1-cycle read latency,
// expected words queued at load time and compared as they leave on valid/ready.
module tb_fifo_reader;

  localparam int DW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          empty_fifo;
  logic          almost_empty_fifo;
  logic          error;
  logic [DW-1:0] fifo_data;
  logic          rd_enable;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          err_o;
  logic [CW-1:0] words_read;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int   cyc         = 0;
  int   rd_total    = 0;
  int   xfer_total  = 0;
  int   first_rd    = -1;
  int   first_valid = -1;
  int   last_xfer   = -1;
  int   max_occ     = 0;
  logic rd_seen     = 1'b0;

  always #5 clk = ~clk;

  fifo_reader #(
    .data_width  (DW),
    .count_width (CW)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .empty_fifo        (empty_fifo),
    .almost_empty_fifo (almost_empty_fifo),
    .error             (error),
    .fifo_data         (fifo_data),
    .rd_enable         (rd_enable),
    .data_o            (data_o),
    .valid_o           (valid_o),
    .ready_i           (ready_i),
    .err_o             (err_o),
    .words_read        (words_read)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic update_flags();
    empty_fifo        = (fifo_q.size() == 0);
    almost_empty_fifo = (fifo_q.size() <= 1);
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    update_flags();
  endtask

  // One clock: observe at the falling edge, then model the FIFO's registered read.
  task automatic cycle();
    logic [DW-1:0] want;
    @(negedge clk);
    rd_seen = rd_enable;
    if (!reset) begin
      if (rd_enable) begin
        rd_total++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (valid_o && first_valid < 0) first_valid = cyc;
      if (int'(dut.occ) > max_occ) max_occ = int'(dut.occ);
      if (valid_o && ready_i) begin
        xfer_total++;
        last_xfer = cyc;
        if (exp_q.size() == 0) begin
          check("xfer_unexpected", 32'(data_o), 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          check("data_o", 32'(data_o), 32'(want));
        end
        $display("cycle %0d: transfer data_o=0x%03h words_read=%0d", cyc, data_o, words_read);
      end
    end
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    update_flags();
    cyc++;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    ready_i = 1'b0;
    error   = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    update_flags();
    repeat (2) cycle();
  endtask

  task automatic clear_track();
    first_rd    = -1;
    first_valid = -1;
    last_xfer   = -1;
    xfer_total  = 0;
    max_occ     = 0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic drain_toggle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < budget) begin
      cycle();
      ready_i = ~ready_i;
      n++;
    end
    check("drain_toggle_left", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_before;
    logic [DW-1:0] w;
    reset     = 1'b1;
    ready_i   = 1'b0;
    error     = 1'b0;
    fifo_data = '0;
    update_flags();

    // Reset held with a non-empty FIFO
    do_reset();
    load(10'h090); load(10'h1A9); load(10'h239); load(10'h04F);
    ready_i = 1'b1;
    repeat (3) cycle();
    check("rst_rd_enable", 32'(rd_enable), 32'd0);
    check("rst_valid_o", 32'(valid_o), 32'd0);
    check("rst_data_o", 32'(data_o), 32'd0);
    check("rst_words_read", 32'(words_read), 32'd0);
    check("rst_err_o", 32'(err_o), 32'd0);

    // Streaming drain with ready_i held high
    clear_track();
    reset = 1'b0;
    drain(30);
    check("latency_rd_to_valid", 32'(first_valid - first_rd), 32'd2);
    check("back_to_back", 32'(last_xfer - first_valid), 32'd3);
    check("t2_xfers", 32'(xfer_total), 32'd4);
    check("t2_words_read", 32'(words_read), 32'd4);
    repeat (3) cycle();
    check("t2_idle_rd_enable", 32'(rd_enable), 32'd0);

    // Consumer stalled: only two reads may be issued
    do_reset();
    load(10'h090); load(10'h1A9); load(10'h239); load(10'h04F);
    clear_track();
    reset = 1'b0;
    rd_before = rd_total;
    repeat (6) cycle();
    check("stall_reads", 32'(rd_total - rd_before), 32'd2);
    check("stall_valid_o", 32'(valid_o), 32'd1);
    check("stall_head", 32'(data_o), 32'h090);
    check("stall_occ", 32'(dut.occ), 32'd2);
    ready_i = 1'b1;
    drain(30);
    check("t3_words_read", 32'(words_read), 32'd4);

    // ready_i toggling every cycle with six words queued
    do_reset();
    for (int i = 0; i < 6; i++) begin
      w = DW'($urandom_range(0, 1023));
      load(w);
    end
    clear_track();
    ready_i = 1'b1;
    reset   = 1'b0;
    drain_toggle(80);
    check("t4_words_read", 32'(words_read), 32'd6);
    check("t4_occ_bound", 32'(max_occ <= 2), 32'd1);

    // Sticky error, then reset in the middle of a drain
    do_reset();
    reset = 1'b0;
    cycle();
    error = 1'b1;
    cycle();
    error = 1'b0;
    repeat (3) cycle();
    check("err_sticky", 32'(err_o), 32'd1);
    for (int i = 0; i < 6; i++) load(DW'(10'h300 + i));
    ready_i = 1'b1;
    repeat (5) cycle();
    check("err_still_set", 32'(err_o), 32'd1);
    check("mid_drain_active", 32'(words_read != 0), 32'd1);
    reset = 1'b1;
    cycle();
    check("mid_rst_valid_o", 32'(valid_o), 32'd0);
    check("mid_rst_words_read", 32'(words_read), 32'd0);
    check("mid_rst_err_o", 32'(err_o), 32'd0);
    fifo_q.delete();
    exp_q.delete();
    update_flags();
    cycle();
    reset = 1'b0;
    repeat (3) cycle();
    check("post_rst_valid_o", 32'(valid_o), 32'd0);

`ifdef FIFO_READER_LOWWATER_EN
    // Burst start: wait for the almost-empty threshold to be passed
    do_reset();
    load(10'h155);
    clear_track();
    ready_i = 1'b1;
    reset   = 1'b0;
    rd_before = rd_total;
    repeat (5) cycle();
    check("lw_no_read", 32'(rd_total - rd_before), 32'd0);
    check("lw_no_valid", 32'(valid_o), 32'd0);
    load(10'h2AA); load(10'h011); load(10'h3C3);
    drain(30);
    check("lw_words_read", 32'(words_read), 32'd4);
    repeat (3) cycle();
    check("lw_back_idle", 32'(dut.state_reg), 32'd0);
    check("lw_rd_enable", 32'(rd_enable), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
